soc_mem_arbiter: RTL and testbench
==================================

// Module: soc_mem_arbiter
// PURPOSE
//  N-master to 1-port memory arbiter between the SoC bus masters (core data port, jtag mem port, future DMA) and the
//  shared single-port ram. Generalises the fixed core/jtag wiring of the SoC top. Adds:
//  - parametrised master count and read latency;
//  - fixed-priority or round-robin arbitration;
//  - halt masking driven by the jtag halt request.
// PARAMETERS
//  DW        32  data width; byte strobes are DW/8 bits
//  AW        32  address width
//  NM        2   number of masters, 2..8; master NM-1 is the debug (jtag) master
//  RD_LAT    1   ram read latency in cycles, 1..4
//  ARB_MODE  0   0 = fixed priority (master 0 highest), 1 = round-robin
// PORTS
//  clk       in   1        system clock
//  rstn      in   1        asynchronous active-low reset
//  m_req     in   NM       per-master request; hold req/we/wstrb/addr/wdata stable until m_gnt
//  m_we      in   NM       1 = write, 0 = read
//  m_wstrb   in   NM*DW/8  byte enables, master i at [i*DW/8 +: DW/8]
//  m_addr    in   NM*AW    address, master i at [i*AW +: AW]
//  m_wdata   in   NM*DW    write data, master i at [i*DW +: DW]
//  halt_i    in   1        debug halt: only master NM-1 may be granted while high
//  m_gnt     out  NM       one-hot, 1-cycle pulse: request accepted this cycle (combinational)
//  m_rvalid  out  NM       one-hot, 1-cycle pulse: read data for that master on m_rdata (registered)
//  m_rdata   out  DW       shared read data, qualified by m_rvalid (registered, holds last value)
//  s_wen     out  DW/8     ram byte write enables
//  s_ren     out  1        ram read enable
//  s_addr    out  AW       ram address
//  s_wdata   out  DW       ram write data
//  s_rdata   in   DW       ram read data, valid in cycle T+RD_LAT for s_ren in cycle T
//  busy      out  1        high while a read is in flight (state != IDLE)
// BEHAVIOUR
//  Reset values: state IDLE, rr pointer = NM-1, counter 0, m_rvalid 0, m_rdata 0. With no grant, the combinational
//    outputs m_gnt, s_wen, s_ren, s_addr and s_wdata are 0.
//  FSM IDLE:
//    - eligible = m_req & (halt_i ? (1<<(NM-1)) : all ones).
//    - If eligible != 0, pick winner w and assert m_gnt[w] in the same cycle T.
//    - s_addr/s_wdata = master w fields.
//    - Write: s_wen = m_wstrb[w]; state stays IDLE, so the next grant is possible at T+1.
//    - Read: s_ren = 1; owner <= w; state -> WAIT; counter <= 0.
//  FSM WAIT: no grants; all s_* = 0.
//    - Counter increments each cycle.
//    - In the cycle where counter == RD_LAT-1 (cycle T+RD_LAT): m_rdata <= s_rdata, m_rvalid[owner] <= 1, state -> IDLE.
//    - m_rvalid is seen in T+RD_LAT+1, when the arbiter is already IDLE and may grant again.
//    - Read-to-data latency is RD_LAT+1; peak read rate is one per RD_LAT+1 cycles; peak write rate is one per cycle.
//  Arbitration:
//    - ARB_MODE 0: lowest index among eligible wins.
//    - ARB_MODE 1: first eligible searching from ptr+1 upward, wrapping at NM. ptr <= w on every grant (read or write).
//  Write with m_wstrb == 0: still granted (m_gnt pulses); s_wen = 0, so no ram change.
//  A master may drop m_req before m_gnt (withdraw). It may not change fields while m_req is high and ungranted.
//  halt_i only masks new grants; an in-flight read completes normally. halt_i rising in WAIT: read still completes.
//  Requests arriving during WAIT stall (no m_gnt) until the cycle the FSM is back in IDLE.
//  Reset asserted mid-read: FSM -> IDLE immediately, no m_rvalid is issued, ptr -> NM-1.
//  Exactly one bit of m_gnt and of m_rvalid is ever high; s_wen and s_ren are never both nonzero.
// TESTING
//  1) ARB_MODE0, NM=2: m0 and m1 both write, same cycle -> m_gnt=01, s_wen=m0 strobe; next cycle m_gnt=10.
//  2) ARB_MODE1, NM=3: all three hold write req for 6 cycles -> grant order 0,1,2,0,1,2; each master 2 grants.
//  3) RD_LAT=2: m0 reads 0x100 at T (ram holds 0xDEADBEEF) -> busy at T+1..T+2;
//     m_rvalid=01 with m_rdata=0xDEADBEEF at T+3.
//  4) halt_i=1, NM=2: m0 and m1 request -> only m1 granted. m0 stays ungranted until halt_i=0, then granted next cycle.
//  5) Read in flight (RD_LAT=3), rstn low at T+1 for 1 cycle -> no m_rvalid ever; state IDLE; first post-reset grant to m0.
//  6) m1 write requested during m0 read WAIT -> m_gnt[1] stalls, then is asserted in the m0 rvalid cycle.
//     Write with wstrb=0 -> gnt pulses, memory unchanged.

Source files
------------

// File: rtl/soc_mem_arbiter.sv
// N-master to single-port RAM arbiter with fixed-priority or round-robin selection,
// debug-halt grant masking and a fixed-latency read return path.
module soc_mem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int NM       = 2,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NM-1:0]        m_req,
    input  logic [NM-1:0]        m_we,
    input  logic [NM*DW/8-1:0]   m_wstrb,
    input  logic [NM*AW-1:0]     m_addr,
    input  logic [NM*DW-1:0]     m_wdata,
    input  logic                 halt_i,
    output logic [NM-1:0]        m_gnt,
    output logic [NM-1:0]        m_rvalid,
    output logic [DW-1:0]        m_rdata,
    output logic [DW/8-1:0]      s_wen,
    output logic                 s_ren,
    output logic [AW-1:0]        s_addr,
    output logic [DW-1:0]        s_wdata,
    input  logic [DW-1:0]        s_rdata,
    output logic                 busy
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(NM);
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [NM-1:0] DBG_MASK = {1'b1, {(NM-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   owner_r;
    logic [CW-1:0]   cnt_r;
    logic [NM-1:0]   elig_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   idx_s;
    logic            found_s;
    logic            last_s;
    int              sum_v;

    // While halted only the debug master stays eligible.
    assign elig_s = m_req & (halt_i ? DBG_MASK : {NM{1'b1}});
    assign busy   = (state_r != ST_IDLE);

    // Winner search: from index 0 in fixed mode, from ptr+1 with wrap in round-robin mode.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        sum_v   = 0;
        idx_s   = '0;
        for (int i = 0; i < NM; i++) begin
            sum_v   = (ARB_MODE == 1) ? (int'(ptr_r) + 1 + i) : i;
            idx_s   = IW'((sum_v >= NM) ? (sum_v - NM) : sum_v);
            win_s   = (elig_s[idx_s] && !found_s) ? idx_s : win_s;
            found_s = found_s | elig_s[idx_s];
        end
    end

    // Next-state and RAM-side/grant outputs.
    always_comb begin
        state_nx_s = state_r;
        m_gnt      = '0;
        s_wen      = '0;
        s_ren      = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        last_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    m_gnt[win_s] = 1'b1;
                    s_addr       = m_addr[int'(win_s)*AW +: AW];
                    s_wdata      = m_wdata[int'(win_s)*DW +: DW];
                    if (m_we[win_s]) begin
                        s_wen      = m_wstrb[int'(win_s)*SW +: SW];
                        state_nx_s = ST_IDLE;
                    end else begin
                        s_ren      = 1'b1;
                        state_nx_s = ST_WAIT;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CW'(RD_LAT - 1)) begin
                    last_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register, latency counter and read owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (s_ren) begin
                owner_r <= win_s;
                cnt_r   <= '0;
            end else if (state_r == ST_WAIT) begin
                cnt_r   <= cnt_r + CW'(1);
            end else begin
                cnt_r   <= cnt_r;
            end
        end
    end

    // Round-robin pointer follows every accepted request, read or write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_r <= IW'(NM - 1);
        end else if (|m_gnt) begin
            ptr_r <= win_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Read return: data held until the next completion, valid pulses for one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_rvalid <= '0;
            m_rdata  <= '0;
        end else begin
            m_rvalid <= '0;
            if (last_s) begin
                m_rdata           <= s_rdata;
                m_rvalid[owner_r] <= 1'b1;
            end else begin
                m_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Directed bench for soc_mem_arbiter: instance A (NM=2, RD_LAT=2, fixed priority)
// and instance B (NM=3, RD_LAT=3, round-robin), each with its own RAM model.
module tb_soc_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        a_rstn, a_halt, a_sren, a_busy;
    logic [1:0]  a_req, a_we, a_gnt, a_rvalid;
    logic [7:0]  a_wstrb;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
    logic [3:0]  a_swen;

    logic        b_rstn, b_halt, b_sren, b_busy;
    logic [2:0]  b_req, b_we, b_gnt, b_rvalid;
    logic [11:0] b_wstrb;
    logic [95:0] b_addr, b_wdata;
    logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
    logic [3:0]  b_swen;

    soc_mem_arbiter #(.DW(32), .AW(32), .NM(2), .RD_LAT(2), .ARB_MODE(0)) dut_a (
        .clk(clk), .rstn(a_rstn), .m_req(a_req), .m_we(a_we), .m_wstrb(a_wstrb),
        .m_addr(a_addr), .m_wdata(a_wdata), .halt_i(a_halt), .m_gnt(a_gnt),
        .m_rvalid(a_rvalid), .m_rdata(a_rdata), .s_wen(a_swen), .s_ren(a_sren),
        .s_addr(a_saddr), .s_wdata(a_swdata), .s_rdata(a_srdata), .busy(a_busy)
    );

    soc_mem_arbiter #(.DW(32), .AW(32), .NM(3), .RD_LAT(3), .ARB_MODE(1)) dut_b (
        .clk(clk), .rstn(b_rstn), .m_req(b_req), .m_we(b_we), .m_wstrb(b_wstrb),
        .m_addr(b_addr), .m_wdata(b_wdata), .halt_i(b_halt), .m_gnt(b_gnt),
        .m_rvalid(b_rvalid), .m_rdata(b_rdata), .s_wen(b_swen), .s_ren(b_sren),
        .s_addr(b_saddr), .s_wdata(b_swdata), .s_rdata(b_srdata), .busy(b_busy)
    );

    // RAM models: word index from addr[9:2], read data after RD_LAT cycles.
    logic [31:0] mem_a [0:255] = '{64: 32'hDEADBEEF, default: 32'h0};
    logic [31:0] mem_b [0:255] = '{64: 32'hCAFEF00D, default: 32'h0};
    logic [7:0]  pa0, pa1, pb0, pb1, pb2;

    always @(posedge clk) begin
        pa0 <= a_saddr[9:2];
        pa1 <= pa0;
        for (int k = 0; k < 4; k++) begin
            if (a_swen[k]) mem_a[a_saddr[9:2]][8*k +: 8] <= a_swdata[8*k +: 8];
        end
    end
    assign a_srdata = mem_a[pa1];

    always @(posedge clk) begin
        pb0 <= b_saddr[9:2];
        pb1 <= pb0;
        pb2 <= pb1;
        for (int k = 0; k < 4; k++) begin
            if (b_swen[k]) mem_b[b_saddr[9:2]][8*k +: 8] <= b_swdata[8*k +: 8];
        end
    end
    assign b_srdata = mem_b[pb2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int   g0, g1, g2;
    logic rv_seen;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rstn = 1'b0; a_halt = 1'b0; a_req = '0; a_we = '0; a_wstrb = '0; a_addr = '0; a_wdata = '0;
        b_rstn = 1'b0; b_halt = 1'b0; b_req = '0; b_we = '0; b_wstrb = '0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        smp();
        chk("rst_a_gnt",    64'(a_gnt),    64'h0);
        chk("rst_a_rvalid", 64'(a_rvalid), 64'h0);
        chk("rst_a_rdata",  64'(a_rdata),  64'h0);
        chk("rst_a_busy",   64'(a_busy),   64'h0);
        chk("rst_a_saddr",  64'(a_saddr),  64'h0);
        chk("rst_b_gnt",    64'(b_gnt),    64'h0);
        chk("rst_b_busy",   64'(b_busy),   64'h0);

        // Fixed priority: simultaneous writes, m0 first then m1
        cyc();
        a_req = 2'b11; a_we = 2'b11; a_wstrb = 8'b1100_0011;
        a_addr = {32'h20, 32'h10}; a_wdata = {32'h33334444, 32'h11112222};
        smp();
        chk("fp_gnt0",   64'(a_gnt),    64'h1);
        chk("fp_wen0",   64'(a_swen),   64'h3);
        chk("fp_addr0",  64'(a_saddr),  64'h10);
        chk("fp_wdata0", 64'(a_swdata), 64'h11112222);
        chk("fp_ren0",   64'(a_sren),   64'h0);
        cyc();
        a_req = 2'b10;
        smp();
        chk("fp_gnt1",  64'(a_gnt),   64'h2);
        chk("fp_wen1",  64'(a_swen),  64'hC);
        chk("fp_addr1", 64'(a_saddr), 64'h20);
        cyc();
        a_req = 2'b00; a_we = 2'b00;
        smp();
        chk("idle_gnt",   64'(a_gnt),    64'h0);
        chk("idle_wen",   64'(a_swen),   64'h0);
        chk("idle_addr",  64'(a_saddr),  64'h0);
        chk("idle_wdata", 64'(a_swdata), 64'h0);

        // Read with RD_LAT=2
        cyc();
        a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h100;
        smp();
        chk("rd_gnt",   64'(a_gnt),   64'h1);
        chk("rd_ren",   64'(a_sren),  64'h1);
        chk("rd_addr",  64'(a_saddr), 64'h100);
        chk("rd_busy0", 64'(a_busy),  64'h0);
        cyc();
        a_req = 2'b00;
        smp();
        chk("rd_busy1", 64'(a_busy),   64'h1);
        chk("rd_gnt1",  64'(a_gnt),    64'h0);
        chk("rd_rv1",   64'(a_rvalid), 64'h0);
        cyc(); smp();
        chk("rd_busy2", 64'(a_busy),   64'h1);
        chk("rd_rv2",   64'(a_rvalid), 64'h0);
        cyc(); smp();
        chk("rd_rv3",   64'(a_rvalid), 64'h1);
        chk("rd_data3", 64'(a_rdata),  64'hDEADBEEF);
        chk("rd_busy3", 64'(a_busy),   64'h0);
        cyc(); smp();
        chk("rd_rv4",   64'(a_rvalid), 64'h0);
        chk("rd_hold4", 64'(a_rdata),  64'hDEADBEEF);

        // Halt masking
        cyc();
        a_halt = 1'b1; a_req = 2'b11; a_we = 2'b11; a_wstrb = 8'h00; a_addr = {32'h40, 32'h44};
        smp();
        chk("halt_gnt_dbg", 64'(a_gnt), 64'h2);
        cyc();
        a_req = 2'b01;
        smp();
        chk("halt_block", 64'(a_gnt), 64'h0);
        cyc();
        a_halt = 1'b0;
        smp();
        chk("halt_release", 64'(a_gnt), 64'h1);

        // Halt rising during WAIT does not cancel the read
        cyc();
        a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h20;
        smp();
        chk("hw_gnt", 64'(a_gnt), 64'h1);
        cyc();
        a_req = 2'b00; a_halt = 1'b1;
        cyc(); cyc(); smp();
        chk("hw_rv",   64'(a_rvalid), 64'h1);
        chk("hw_data", 64'(a_rdata),  64'h33330000);
        cyc();
        a_halt = 1'b0;

        // Write stalls during WAIT, granted in the rvalid cycle; zero strobe writes nothing
        a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h10;
        smp();
        chk("st_rd_gnt", 64'(a_gnt), 64'h1);
        cyc();
        a_req = 2'b10; a_we = 2'b10; a_wstrb = 8'h00; a_addr[63:32] = 32'h100; a_wdata[63:32] = 32'hFFFFFFFF;
        smp();
        chk("st_stall1", 64'(a_gnt), 64'h0);
        cyc(); smp();
        chk("st_stall2", 64'(a_gnt), 64'h0);
        cyc(); smp();
        chk("st_rv",     64'(a_rvalid), 64'h1);
        chk("st_data",   64'(a_rdata),  64'h00002222);
        chk("st_gnt",    64'(a_gnt),    64'h2);
        chk("st_wen0",   64'(a_swen),   64'h0);
        cyc();
        a_req = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h100;
        smp();
        chk("z_rd_gnt", 64'(a_gnt), 64'h1);
        cyc();
        a_req = 2'b00;
        cyc(); cyc(); smp();
        chk("z_rv",   64'(a_rvalid), 64'h1);
        chk("z_data", 64'(a_rdata),  64'hDEADBEEF);

        // Round-robin, three masters holding write requests
        cyc();
        b_req = 3'b111; b_we = 3'b111; b_wstrb = 12'h000;
        g0 = 0; g1 = 0; g2 = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk($sformatf("rr_gnt%0d", i), 64'(b_gnt), 64'(1 << (i % 3)));
            g0 += int'(b_gnt[0]);
            g1 += int'(b_gnt[1]);
            g2 += int'(b_gnt[2]);
            cyc();
        end
        chk("rr_cnt0", 64'(g0), 64'd2);
        chk("rr_cnt1", 64'(g1), 64'd2);
        chk("rr_cnt2", 64'(g2), 64'd2);
        b_req = 3'b110;
        smp();
        chk("rr_skip0", 64'(b_gnt), 64'h2);
        cyc();
        b_req = 3'b101;
        smp();
        chk("rr_wrap", 64'(b_gnt), 64'h4);
        cyc();

        // Reset in the middle of a read
        b_req = 3'b001; b_we = 3'b000; b_addr[31:0] = 32'h100;
        smp();
        chk("mr_gnt", 64'(b_gnt),  64'h1);
        chk("mr_ren", 64'(b_sren), 64'h1);
        cyc();
        b_req = 3'b000; b_rstn = 1'b0;
        smp();
        chk("mr_busy",   64'(b_busy),   64'h0);
        chk("mr_rvalid", 64'(b_rvalid), 64'h0);
        cyc();
        b_rstn = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            smp();
            rv_seen = rv_seen | (|b_rvalid);
            cyc();
        end
        chk("mr_no_rvalid", 64'(rv_seen), 64'h0);
        b_req = 3'b111; b_we = 3'b111; b_wstrb = 12'h000;
        smp();
        chk("mr_first_gnt", 64'(b_gnt), 64'h1);
        cyc();
        b_req = 3'b000; b_we = 3'b000;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
